// File: rtl/keccak_p_round_sequencer.sv
// keccak_p_round_sequencer: valid/ready round controller for Keccak-p[25*2^L, nr], UNROLL rounds per cycle
module keccak_p_round_sequencer #(
    parameter int L = 6,
    parameter int UNROLL = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start_valid,
    output logic                  o_start_ready,
    input  logic [4:0]            i_num_rounds,
    input  logic                  i_abort,
    input  logic                  i_out_ready,
    output logic                  o_out_valid,
    output logic                  o_sel_input,
    output logic                  o_load_en,
    output logic [UNROLL-1:0]     o_stage_en,
    output logic [5*UNROLL-1:0]   o_round_idx,
    output logic                  o_busy,
    output logic                  o_mode,
    output logic                  o_err
);
    localparam int NR_MAX = 12 + 2 * L;
    localparam int CW = $clog2(NR_MAX + UNROLL + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [4:0]    nr_q;
    logic [4:0]    base_q;
    logic          mode_q;
    logic          err_q;
    logic          accept;
    logic          legal;
    logic          active;
    logic [31:0]   pos;
    logic [31:0]   nr_cur;
    logic [31:0]   base_cur;
    logic [UNROLL-1:0] en;

    assign o_start_ready = ~i_abort & ((state == IDLE) | ((state == DONE) & i_out_ready));
    assign accept = i_start_valid & o_start_ready;
    assign legal = (i_num_rounds != 5'd0) && (32'(i_num_rounds) <= NR_MAX);
    assign active = (accept & legal) | (state == RUN);

    // cnt holds the round offset of stage 0; the accept cycle decodes straight from the inputs
    assign pos = accept ? 32'd0 : 32'(cnt);
    assign nr_cur = accept ? 32'(i_num_rounds) : 32'(nr_q);
    assign base_cur = accept ? 32'(NR_MAX) - 32'(i_num_rounds) : 32'(base_q);

    for (genvar k = 0; k < UNROLL; k++) begin : g_stage
        assign en[k] = active && ((pos + 32'(k)) < nr_cur);
        assign o_round_idx[5*k +: 5] = en[k] ? 5'(base_cur + pos + 32'(k)) : 5'd0;
    end

    assign o_stage_en = en;
    assign o_load_en = active;
    assign o_sel_input = state == RUN;
    assign o_out_valid = state == DONE;
    assign o_busy = state != IDLE;
    assign o_mode = mode_q;
    assign o_err = err_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            cnt <= '0;
            nr_q <= '0;
            base_q <= '0;
            mode_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            err_q <= accept & ~legal;
            if (accept & legal) begin
                nr_q <= i_num_rounds;
                base_q <= 5'(32'(NR_MAX) - 32'(i_num_rounds));
                mode_q <= 32'(i_num_rounds) == NR_MAX;
                cnt <= CW'(UNROLL);
                state <= (32'(i_num_rounds) > UNROLL) ? RUN : DONE;
            end else if (accept | i_abort) begin
                state <= IDLE;
            end else if (state == RUN) begin
                state <= ((32'(cnt) + UNROLL) >= 32'(nr_q)) ? DONE : RUN;
                cnt <= CW'(32'(cnt) + UNROLL);
            end else if ((state == DONE) && i_out_ready) begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_keccak_p_round_sequencer.sv
// tb_keccak_p_round_sequencer: directed bench for the round sequencer at UNROLL=1 and UNROLL=4
module tb_keccak_p_round_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic       a_valid, a_abort, a_oready, a_ready, a_ov, a_sel, a_ld, a_busy, a_mode, a_err;
    logic [4:0] a_nr, a_idx;
    logic [0:0] a_en;
    logic       b_valid, b_abort, b_oready, b_ready, b_ov, b_sel, b_ld, b_busy, b_mode, b_err;
    logic [4:0] b_nr;
    logic [19:0] b_idx;
    logic [3:0] b_en;

    int tests = 0;
    int fails = 0;

    keccak_p_round_sequencer #(.L(6), .UNROLL(1)) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start_valid(a_valid), .o_start_ready(a_ready),
        .i_num_rounds(a_nr), .i_abort(a_abort), .i_out_ready(a_oready), .o_out_valid(a_ov),
        .o_sel_input(a_sel), .o_load_en(a_ld), .o_stage_en(a_en), .o_round_idx(a_idx),
        .o_busy(a_busy), .o_mode(a_mode), .o_err(a_err)
    );

    keccak_p_round_sequencer #(.L(6), .UNROLL(4)) u4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start_valid(b_valid), .o_start_ready(b_ready),
        .i_num_rounds(b_nr), .i_abort(b_abort), .i_out_ready(b_oready), .o_out_valid(b_ov),
        .o_sel_input(b_sel), .o_load_en(b_ld), .o_stage_en(b_en), .o_round_idx(b_idx),
        .o_busy(b_busy), .o_mode(b_mode), .o_err(b_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        @(negedge clk);
    endtask

    task automatic test_reset;
        {a_valid, a_abort, a_oready, a_nr} = '0;
        {b_valid, b_abort, b_oready, b_nr} = '0;
        #1 rst_n = 1'b0;
        #2;
        tests++;
        if ({a_ov, a_ld, a_en, a_idx, a_busy, a_mode, a_err} !== 11'd0) begin
            fails++;
            $display("FAIL reset_outs_u1 got %b exp 0", {a_ov, a_ld, a_en, a_idx, a_busy, a_mode, a_err});
        end
        tests++;
        if ({b_ov, b_ld, b_en, b_idx, b_busy, b_mode, b_err} !== 30'd0) begin
            fails++;
            $display("FAIL reset_outs_u4 got %b exp 0", {b_ov, b_ld, b_en, b_idx, b_busy, b_mode, b_err});
        end
        tests++;
        if ({a_ready, b_ready} !== 2'b11) begin
            fails++;
            $display("FAIL reset_ready got %b exp 11", {a_ready, b_ready});
        end
        repeat (2) settle;
        rst_n = 1'b1;
    endtask

    task automatic test_full_24;
        tick;
        a_valid = 1'b1;
        a_nr = 5'd24;
        a_oready = 1'b0;
        settle;
        tests++;
        if ({a_ready, a_ld, a_sel, a_en, a_idx} !== {4'b1101, 5'd0}) begin
            fails++;
            $display("FAIL full_accept got %b exp 110100000", {a_ready, a_ld, a_sel, a_en, a_idx});
        end
        for (int j = 1; j < 24; j++) begin
            tick;
            a_valid = 1'b0;
            settle;
            tests++;
            if ({a_ld, a_sel, a_en, a_ov, a_idx} !== {4'b1110, 5'(j)}) begin
                fails++;
                $display("FAIL full_run j=%0d got %b exp %b", j, {a_ld, a_sel, a_en, a_ov, a_idx}, {4'b1110, 5'(j)});
            end
        end
        tick;
        settle;
        tests++;
        if ({a_ov, a_ld, a_en, a_mode, a_idx} !== {4'b1001, 5'd0}) begin
            fails++;
            $display("FAIL full_done got %b exp 100100000", {a_ov, a_ld, a_en, a_mode, a_idx});
        end
        a_oready = 1'b1;
        tick;
        a_oready = 1'b0;
        settle;
        tests++;
        if ({a_busy, a_ov} !== 2'b00) begin
            fails++;
            $display("FAIL full_idle got %b exp 00", {a_busy, a_ov});
        end
    endtask

    task automatic test_unroll4;
        logic [19:0] e;
        tick;
        b_valid = 1'b1;
        b_nr = 5'd12;
        b_oready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            if (j > 0) begin
                tick;
                b_valid = 1'b0;
            end
            settle;
            for (int k = 0; k < 4; k++) e[5*k +: 5] = 5'(12 + 4 * j + k);
            tests++;
            if ({b_ld, b_sel, b_en, b_idx} !== {1'b1, j != 0, 4'hF, e}) begin
                fails++;
                $display("FAIL u4_nr12 j=%0d got %h exp %h", j, {b_ld, b_sel, b_en, b_idx}, {1'b1, j != 0, 4'hF, e});
            end
        end
        tick;
        settle;
        tests++;
        if ({b_ov, b_mode, b_ld, b_en} !== 7'b1000000) begin
            fails++;
            $display("FAIL u4_done got %b exp 1000000", {b_ov, b_mode, b_ld, b_en});
        end
        tick;
        b_oready = 1'b1;
        b_valid = 1'b1;
        b_nr = 5'd5;
        settle;
        tests++;
        if ({b_ready, b_ov, b_ld, b_sel, b_en, b_idx} !== {4'b1110, 4'hF, 5'd22, 5'd21, 5'd20, 5'd19}) begin
            fails++;
            $display("FAIL u4_nr5_j0 got %h exp %h", {b_ready, b_ov, b_ld, b_sel, b_en, b_idx},
                     {4'b1110, 4'hF, 5'd22, 5'd21, 5'd20, 5'd19});
        end
        tick;
        b_valid = 1'b0;
        b_oready = 1'b0;
        settle;
        tests++;
        if ({b_ov, b_ld, b_sel, b_en, b_idx} !== {3'b011, 4'b0001, 20'd23}) begin
            fails++;
            $display("FAIL u4_nr5_j1 got %h exp %h", {b_ov, b_ld, b_sel, b_en, b_idx}, {3'b011, 4'b0001, 20'd23});
        end
        tick;
        settle;
        tests++;
        if (b_ov !== 1'b1) begin
            fails++;
            $display("FAIL u4_nr5_done got %b exp 1", b_ov);
        end
        b_oready = 1'b1;
        tick;
        b_oready = 1'b0;
        settle;
    endtask

    task automatic test_single_hold;
        tick;
        a_valid = 1'b1;
        a_nr = 5'd1;
        a_oready = 1'b0;
        settle;
        tests++;
        if ({a_ld, a_en, a_idx} !== {2'b11, 5'd23}) begin
            fails++;
            $display("FAIL single_accept got %b exp 1110111", {a_ld, a_en, a_idx});
        end
        tick;
        a_valid = 1'b0;
        for (int i = 0; i < 11; i++) begin
            settle;
            tests++;
            if ({a_ov, a_ld, a_en} !== 3'b100) begin
                fails++;
                $display("FAIL single_hold i=%0d got %b exp 100", i, {a_ov, a_ld, a_en});
            end
            if (i < 10) tick;
        end
        tick;
        a_oready = 1'b1;
        a_valid = 1'b1;
        a_nr = 5'd2;
        settle;
        tests++;
        if ({a_ready, a_ov, a_ld, a_sel, a_idx} !== {4'b1110, 5'd22}) begin
            fails++;
            $display("FAIL b2b_accept got %b exp 111010110", {a_ready, a_ov, a_ld, a_sel, a_idx});
        end
        tick;
        a_valid = 1'b0;
        a_oready = 1'b0;
        settle;
        tests++;
        if ({a_busy, a_sel, a_ov, a_idx} !== {3'b110, 5'd23}) begin
            fails++;
            $display("FAIL b2b_run got %b exp 11010111", {a_busy, a_sel, a_ov, a_idx});
        end
        tick;
        settle;
        tests++;
        if (a_ov !== 1'b1) begin
            fails++;
            $display("FAIL b2b_done got %b exp 1", a_ov);
        end
        a_oready = 1'b1;
        tick;
        a_oready = 1'b0;
        settle;
    endtask

    task automatic test_abort;
        int seen;
        tick;
        a_abort = 1'b1;
        a_valid = 1'b1;
        a_nr = 5'd24;
        settle;
        tests++;
        if ({a_ready, a_ld} !== 2'b00) begin
            fails++;
            $display("FAIL abort_idle_block got %b exp 00", {a_ready, a_ld});
        end
        tick;
        a_abort = 1'b0;
        a_valid = 1'b0;
        settle;
        tests++;
        if (a_busy !== 1'b0) begin
            fails++;
            $display("FAIL abort_idle_busy got %b exp 0", a_busy);
        end
        tick;
        a_valid = 1'b1;
        a_nr = 5'd24;
        settle;
        for (int j = 1; j < 8; j++) begin
            tick;
            a_valid = 1'b0;
            settle;
        end
        tests++;
        if ({a_busy, a_idx} !== {1'b1, 5'd7}) begin
            fails++;
            $display("FAIL abort_j7 got %b exp 100111", {a_busy, a_idx});
        end
        a_abort = 1'b1;
        tick;
        a_abort = 1'b0;
        settle;
        tests++;
        if ({a_busy, a_ov, a_ld} !== 3'b000) begin
            fails++;
            $display("FAIL abort_to_idle got %b exp 000", {a_busy, a_ov, a_ld});
        end
        seen = 0;
        repeat (30) begin
            tick;
            settle;
            if (a_ov !== 1'b0) seen++;
        end
        tests++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL abort_no_valid got %0d valid cycles exp 0", seen);
        end
        tick;
        a_valid = 1'b1;
        a_nr = 5'd3;
        for (int j = 0; j < 3; j++) begin
            if (j > 0) begin
                tick;
                a_valid = 1'b0;
            end
            settle;
            tests++;
            if ({a_ld, a_idx} !== {1'b1, 5'(21 + j)}) begin
                fails++;
                $display("FAIL abort_restart j=%0d got %b exp %b", j, {a_ld, a_idx}, {1'b1, 5'(21 + j)});
            end
        end
        tick;
        settle;
        tests++;
        if ({a_ov, a_mode} !== 2'b10) begin
            fails++;
            $display("FAIL abort_restart_done got %b exp 10", {a_ov, a_mode});
        end
        a_oready = 1'b1;
        tick;
        a_oready = 1'b0;
        settle;
    endtask

    task automatic test_illegal;
        logic [4:0] bad [2];
        bad[0] = 5'd0;
        bad[1] = 5'd25;
        for (int i = 0; i < 2; i++) begin
            tick;
            a_valid = 1'b1;
            a_nr = bad[i];
            settle;
            tests++;
            if ({a_ready, a_ld, a_en} !== 3'b100) begin
                fails++;
                $display("FAIL illegal_accept nr=%0d got %b exp 100", bad[i], {a_ready, a_ld, a_en});
            end
            tick;
            a_valid = 1'b0;
            settle;
            tests++;
            if ({a_err, a_busy, a_ld} !== 3'b100) begin
                fails++;
                $display("FAIL illegal_err nr=%0d got %b exp 100", bad[i], {a_err, a_busy, a_ld});
            end
            tick;
            settle;
            tests++;
            if ({a_err, a_busy} !== 2'b00) begin
                fails++;
                $display("FAIL illegal_pulse nr=%0d got %b exp 00", bad[i], {a_err, a_busy});
            end
        end
    endtask

    task automatic test_async_reset;
        tick;
        a_valid = 1'b1;
        a_nr = 5'd24;
        repeat (5) begin
            tick;
            a_valid = 1'b0;
        end
        settle;
        tests++;
        if ({a_busy, a_mode, a_idx} !== {2'b11, 5'd5}) begin
            fails++;
            $display("FAIL async_pre got %b exp 1100101", {a_busy, a_mode, a_idx});
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({a_ov, a_ld, a_sel, a_en, a_idx, a_busy, a_mode, a_err} !== 12'd0) begin
            fails++;
            $display("FAIL async_reset got %b exp 0", {a_ov, a_ld, a_sel, a_en, a_idx, a_busy, a_mode, a_err});
        end
        settle;
        rst_n = 1'b1;
        #1;
        tests++;
        if (a_ready !== 1'b1) begin
            fails++;
            $display("FAIL async_release_ready got %b exp 1", a_ready);
        end
        test_full_24;
    endtask

    initial begin
        test_reset;
        test_full_24;
        test_unroll4;
        test_single_hold;
        test_abort;
        test_illegal;
        test_async_reset;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
